// File: rtl/ctrl_redirect_unit_pkg.sv
// Shared definitions for the control redirect unit.
//   - Bit positions within the execute-stage flag byte.
//   - Recovery FSM state encoding.
//   - Branch-predictor update entry carried through the update FIFO.
package ctrl_redirect_unit_pkg;

  localparam int FLAG_MISPRED  = 0;
  localparam int FLAG_EXC      = 1;
  localparam int FLAG_EXEC     = 2;
  localparam int FLAG_PRED_UPD = 5;

  // Update entries hold PCs at this width; narrower PC_W values are zero-extended.
  localparam int UPD_PC_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    RECOVER
  } state_t;

  typedef struct packed {
    logic [UPD_PC_W-1:0] pc;
    logic [UPD_PC_W-1:0] target;
    logic                dir;
    logic                mispredict;
  } upd_entry_t;

endpackage

// File: rtl/ctrl_upd_fifo.sv
// Synchronous FIFO that buffers branch-predictor training updates.
// Ports:
//   clk, reset  - clock; asynchronous active-low reset (clears pointers/count)
//   push, din   - write request and data (ignored while full)
//   pop         - read request (ignored while empty)
//   dout        - head entry (raw storage; caller masks it when empty)
//   full, empty - occupancy status
module ctrl_upd_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ctrl_redirect_unit.sv
// Control redirect unit: consumes resolved control-transfer results from the
// execute stage, raises a registered fetch redirect for the oldest outstanding
// mispredict, and queues predictor training updates.
// Ports:
//   clk, reset            - clock; asynchronous active-low reset
//   exe_*                 - execute-stage result (valid/ready handshake)
//   rob_head_i            - ROB head tag, reference point for age compare
//   redirect_*            - redirect request to fetch, held until acknowledged
//   busy_o                - recovery FSM not idle
//   upd_*                 - predictor update stream (valid/ready), zero when empty
module ctrl_redirect_unit
  import ctrl_redirect_unit_pkg::*;
#(
  parameter int PC_W           = 32,
  parameter int TAG_W          = 6,
  parameter int UPD_DEPTH      = 4,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exe_valid_i,
  output logic             exe_ready_o,
  input  logic [PC_W-1:0]  exe_pc_i,
  input  logic [PC_W-1:0]  exe_next_pc_i,
  input  logic             exe_dir_i,
  input  logic [7:0]       exe_flags_i,
  input  logic [TAG_W-1:0] exe_tag_i,
  input  logic [TAG_W-1:0] rob_head_i,
  output logic             redirect_valid_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic [TAG_W-1:0] redirect_tag_o,
  input  logic             redirect_ack_i,
  output logic             busy_o,
  output logic             upd_valid_o,
  input  logic             upd_ready_i,
  output logic [PC_W-1:0]  upd_pc_o,
  output logic [PC_W-1:0]  upd_target_o,
  output logic             upd_dir_o,
  output logic             upd_mispredict_o
);

  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam int ENT_W = $bits(upd_entry_t);

  // Age relative to the ROB head; modulo subtraction absorbs tag wrap-around.
  function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] tag,
                                           input logic [TAG_W-1:0] head);
    return tag - head;
  endfunction

  state_t            state, state_nx;
  logic [PC_W-1:0]   rd_pc, rd_pc_nx;
  logic [TAG_W-1:0]  rd_tag, rd_tag_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic              accept;
  logic              usable;
  logic              mis_evt;
  logic              push;
  logic              is_older;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_dout;
  upd_entry_t        push_ent;
  upd_entry_t        head_ent;
  logic              unused_flags;

  assign unused_flags = ^{exe_flags_i[7:6], exe_flags_i[4:3]};

  assign exe_ready_o = !fifo_full;
  assign accept      = exe_valid_i && exe_ready_o;
  // Executed, non-excepting results are the only ones that redirect or train.
  assign usable      = accept && exe_flags_i[FLAG_EXEC] && !exe_flags_i[FLAG_EXC];
  assign mis_evt     = usable && exe_flags_i[FLAG_MISPRED];
  assign push        = usable && exe_flags_i[FLAG_PRED_UPD];
  assign is_older    = age(exe_tag_i, rob_head_i) < age(rd_tag, rob_head_i);

  always_comb begin
    push_ent            = '0;
    push_ent.pc         = UPD_PC_W'(exe_pc_i);
    push_ent.target     = UPD_PC_W'(exe_next_pc_i);
    push_ent.dir        = exe_dir_i;
    push_ent.mispredict = exe_flags_i[FLAG_MISPRED];
  end

  ctrl_upd_fifo #(
    .W     (ENT_W),
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_ent),
    .pop   (upd_valid_o && upd_ready_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_ent         = fifo_empty ? '0 : upd_entry_t'(fifo_dout);
  assign upd_valid_o      = !fifo_empty;
  assign upd_pc_o         = PC_W'(head_ent.pc);
  assign upd_target_o     = PC_W'(head_ent.target);
  assign upd_dir_o        = head_ent.dir;
  assign upd_mispredict_o = head_ent.mispredict;

  // An older mispredict always wins, even in the cycle fetch acknowledges the
  // previous target: the new target must still be delivered. The counter is
  // loaded with RECOVER_CYCLES-1 so RECOVER is occupied RECOVER_CYCLES cycles.
  always_comb begin
    state_nx  = state;
    rd_pc_nx  = rd_pc;
    rd_tag_nx = rd_tag;
    cnt_nx    = cnt;
    case (state)
      IDLE: begin
        if (mis_evt) begin
          state_nx  = REDIRECT;
          rd_pc_nx  = exe_next_pc_i;
          rd_tag_nx = exe_tag_i;
        end
      end
      REDIRECT: begin
        if (mis_evt && is_older) begin
          rd_pc_nx  = exe_next_pc_i;
          rd_tag_nx = exe_tag_i;
        end else if (redirect_ack_i) begin
          state_nx = RECOVER;
          cnt_nx   = CNT_W'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (mis_evt && is_older) begin
          state_nx  = REDIRECT;
          rd_pc_nx  = exe_next_pc_i;
          rd_tag_nx = exe_tag_i;
        end else if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rd_pc  <= '0;
      rd_tag <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      rd_pc  <= rd_pc_nx;
      rd_tag <= rd_tag_nx;
      cnt    <= cnt_nx;
    end
  end

  assign redirect_valid_o = (state == REDIRECT);
  assign redirect_pc_o    = rd_pc;
  assign redirect_tag_o   = rd_tag;
  assign busy_o           = (state != IDLE);

endmodule

// File: tb/tb_ctrl_redirect_unit.sv
module tb_ctrl_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_valid_i;
  logic        exe_ready_o;
  logic [31:0] exe_pc_i;
  logic [31:0] exe_next_pc_i;
  logic        exe_dir_i;
  logic [7:0]  exe_flags_i;
  logic [5:0]  exe_tag_i;
  logic [5:0]  rob_head_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [5:0]  redirect_tag_o;
  logic        redirect_ack_i;
  logic        busy_o;
  logic        upd_valid_o;
  logic        upd_ready_i;
  logic [31:0] upd_pc_o;
  logic [31:0] upd_target_o;
  logic        upd_dir_o;
  logic        upd_mispredict_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_redirect_unit #(
    .PC_W(32), .TAG_W(6), .UPD_DEPTH(4), .RECOVER_CYCLES(3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .exe_valid_i      (exe_valid_i),
    .exe_ready_o      (exe_ready_o),
    .exe_pc_i         (exe_pc_i),
    .exe_next_pc_i    (exe_next_pc_i),
    .exe_dir_i        (exe_dir_i),
    .exe_flags_i      (exe_flags_i),
    .exe_tag_i        (exe_tag_i),
    .rob_head_i       (rob_head_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_tag_o   (redirect_tag_o),
    .redirect_ack_i   (redirect_ack_i),
    .busy_o           (busy_o),
    .upd_valid_o      (upd_valid_o),
    .upd_ready_i      (upd_ready_i),
    .upd_pc_o         (upd_pc_o),
    .upd_target_o     (upd_target_o),
    .upd_dir_o        (upd_dir_o),
    .upd_mispredict_o (upd_mispredict_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] npc, input logic dir,
                       input logic [7:0] flags, input logic [5:0] tag);
    exe_valid_i   = 1'b1;
    exe_pc_i      = pc;
    exe_next_pc_i = npc;
    exe_dir_i     = dir;
    exe_flags_i   = flags;
    exe_tag_i     = tag;
  endtask

  task automatic no_exe();
    exe_valid_i = 1'b0;
    exe_flags_i = 8'h00;
  endtask

  task automatic chk_upd(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic dir, input logic mis);
    chk({tag, "_valid"}, upd_valid_o, 1'b1);
    chk({tag, "_pc"}, upd_pc_o, pc);
    chk({tag, "_target"}, upd_target_o, tgt);
    chk({tag, "_dir"}, upd_dir_o, dir);
    chk({tag, "_mis"}, upd_mispredict_o, mis);
  endtask

  initial begin
    reset = 1'b0; exe_valid_i = 1'b0; exe_pc_i = '0; exe_next_pc_i = '0;
    exe_dir_i = 1'b0; exe_flags_i = '0; exe_tag_i = '0; rob_head_i = '0;
    redirect_ack_i = 1'b0; upd_ready_i = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_rvalid", redirect_valid_o, 1'b0);
    chk("rst_rpc", redirect_pc_o, 32'h0);
    chk("rst_rtag", redirect_tag_o, 6'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_uvalid", upd_valid_o, 1'b0);
    chk("rst_upc", upd_pc_o, 32'h0);
    chk("rst_ready", exe_ready_o, 1'b1);
    reset = 1'b1;
    tick();

    // Basic mispredict, no training bit
    rob_head_i = 6'd0;
    drive(32'h0040_0100, 32'h0040_0200, 1'b1, 8'h05, 6'd5);
    tick();
    no_exe();
    chk("mp_rvalid", redirect_valid_o, 1'b1);
    chk("mp_rpc", redirect_pc_o, 32'h0040_0200);
    chk("mp_rtag", redirect_tag_o, 6'd5);
    chk("mp_busy", busy_o, 1'b1);
    chk("mp_nopush", upd_valid_o, 1'b0);
    tick();
    chk("mp_hold", redirect_valid_o, 1'b1);
    redirect_ack_i = 1'b1;
    tick();
    redirect_ack_i = 1'b0;
    chk("ack_rvalid", redirect_valid_o, 1'b0);
    chk("rec1_busy", busy_o, 1'b1);
    tick();
    chk("rec2_busy", busy_o, 1'b1);
    tick();
    chk("rec3_busy", busy_o, 1'b1);
    tick();
    chk("rec_done_busy", busy_o, 1'b0);

    // Older replacement across tag wrap
    rob_head_i = 6'd60;
    drive(32'h10, 32'h1000, 1'b1, 8'h05, 6'd2);
    tick();
    drive(32'h20, 32'h2000, 1'b1, 8'h05, 6'd62);
    tick();
    chk("wrap_rtag", redirect_tag_o, 6'd62);
    chk("wrap_rpc", redirect_pc_o, 32'h2000);
    drive(32'h30, 32'h3000, 1'b1, 8'h05, 6'd3);
    tick();
    chk("young_drop_tag", redirect_tag_o, 6'd62);
    drive(32'h40, 32'h4000, 1'b1, 8'h05, 6'd62);
    tick();
    chk("equal_drop_pc", redirect_pc_o, 32'h2000);

    // Ack plus older event in the same cycle: stay in REDIRECT with new target
    drive(32'h50, 32'h5000, 1'b1, 8'h05, 6'd61);
    redirect_ack_i = 1'b1;
    tick();
    no_exe();
    chk("ackold_rvalid", redirect_valid_o, 1'b1);
    chk("ackold_rtag", redirect_tag_o, 6'd61);
    chk("ackold_rpc", redirect_pc_o, 32'h5000);
    tick();
    redirect_ack_i = 1'b0;

    // Older mispredict during RECOVER returns to REDIRECT
    chk("rec_state_rvalid", redirect_valid_o, 1'b0);
    drive(32'h70, 32'h7000, 1'b0, 8'h05, 6'd60);
    tick();
    no_exe();
    chk("recold_rvalid", redirect_valid_o, 1'b1);
    chk("recold_rtag", redirect_tag_o, 6'd60);
    chk("recold_rpc", redirect_pc_o, 32'h7000);
    redirect_ack_i = 1'b1;
    tick();
    redirect_ack_i = 1'b0;
    // Younger event during RECOVER is dropped; IDLE on schedule
    drive(32'h80, 32'h8000, 1'b1, 8'h05, 6'd10);
    tick();
    no_exe();
    chk("recyoung_rvalid", redirect_valid_o, 1'b0);
    chk("recyoung_rtag", redirect_tag_o, 6'd60);
    chk("recyoung_busy2", busy_o, 1'b1);
    tick();
    chk("recyoung_busy3", busy_o, 1'b1);
    tick();
    chk("recyoung_idle", busy_o, 1'b0);

    // Exception / unexecuted filtering
    rob_head_i = 6'd0;
    drive(32'h90, 32'h9000, 1'b1, 8'h27, 6'd1);
    tick();
    drive(32'hA0, 32'hA000, 1'b1, 8'h21, 6'd2);
    chk("exc_rvalid", redirect_valid_o, 1'b0);
    chk("exc_nopush", upd_valid_o, 1'b0);
    tick();
    no_exe();
    chk("noexec_busy", busy_o, 1'b0);
    chk("noexec_nopush", upd_valid_o, 1'b0);
    chk("noexec_ready", exe_ready_o, 1'b1);

    // Update FIFO fill, stall and in-order drain
    upd_ready_i = 1'b0;
    drive(32'h100, 32'h180, 1'b1, 8'h24, 6'd4);
    tick();
    chk_upd("u1", 32'h100, 32'h180, 1'b1, 1'b0);
    drive(32'h200, 32'h204, 1'b0, 8'h24, 6'd5);
    tick();
    drive(32'h300, 32'h380, 1'b1, 8'h24, 6'd6);
    tick();
    drive(32'h400, 32'h480, 1'b0, 8'h25, 6'd7);
    tick();
    chk("full_ready", exe_ready_o, 1'b0);
    chk("fifo_mp_rtag", redirect_tag_o, 6'd7);
    chk("fifo_mp_rpc", redirect_pc_o, 32'h480);
    drive(32'h500, 32'h580, 1'b1, 8'h24, 6'd8);
    tick();
    tick();
    no_exe();
    chk("stall_ready", exe_ready_o, 1'b0);
    chk_upd("stall", 32'h100, 32'h180, 1'b1, 1'b0);
    upd_ready_i = 1'b1;
    chk_upd("pop1", 32'h100, 32'h180, 1'b1, 1'b0);
    tick();
    chk_upd("pop2", 32'h200, 32'h204, 1'b0, 1'b0);
    tick();
    chk_upd("pop3", 32'h300, 32'h380, 1'b1, 1'b0);
    tick();
    chk_upd("pop4", 32'h400, 32'h480, 1'b0, 1'b1);
    tick();
    upd_ready_i = 1'b0;
    chk("drained", upd_valid_o, 1'b0);
    chk("drained_ready", exe_ready_o, 1'b1);

    // Two entries queued while still in REDIRECT, then asynchronous reset
    drive(32'h600, 32'h680, 1'b1, 8'h24, 6'd9);
    tick();
    drive(32'h700, 32'h780, 1'b1, 8'h24, 6'd10);
    tick();
    no_exe();
    chk("pre_rst_rvalid", redirect_valid_o, 1'b1);
    chk("pre_rst_upc", upd_pc_o, 32'h600);
    reset = 1'b0;
    #1;
    chk("async_rvalid", redirect_valid_o, 1'b0);
    chk("async_uvalid", upd_valid_o, 1'b0);
    tick();
    chk("mrst_rvalid", redirect_valid_o, 1'b0);
    chk("mrst_rpc", redirect_pc_o, 32'h0);
    chk("mrst_rtag", redirect_tag_o, 6'h0);
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_uvalid", upd_valid_o, 1'b0);
    chk("mrst_upc", upd_pc_o, 32'h0);
    chk("mrst_utgt", upd_target_o, 32'h0);
    chk("mrst_ready", exe_ready_o, 1'b1);
    reset = 1'b1;
    tick();
    chk("post_rst_uvalid", upd_valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
